meas_seq_ctrl: RTL and testbench

MEAS_SEQ_CTRL -- requirements
Module: meas_seq_ctrl

---
 rtl/meas_seq_ctrl.sv | 146 ++++++++++++++
 tb/tb_meas_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/meas_seq_ctrl.sv
// Period-measurement sequencer: discharges the analog front end, then averages
// 2^AVG_LOG2 trigger periods (in clk cycles), with timeout and abort handling.
module meas_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int AVG_LOG2 = 2,
  parameter int RST_CYC  = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             trigger,
  output logic             afe_reset,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] result,
  output logic             overflow
);

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int SC_W  = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int DC_W  = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(RST_CYC - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(NSAMP - 1);

  typedef enum logic [2:0] {IDLE, DISCHARGE, ARM, MEASURE, FINISH} state_t;

  state_t             state_reg, state_next;
  logic               sync1_reg, sync2_reg, sync_prev_reg;
  logic [DC_W-1:0]    disch_cnt_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [SC_W-1:0]    scnt_reg;
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   result_reg;
  logic               overflow_reg;
  logic               rise;
  logic               load_last;
  logic               load_tout;
  logic               counting;

  assign rise      = sync2_reg & ~sync_prev_reg;
  assign acc_sum   = acc_reg + ACC_W'(cnt_reg);
  assign counting  = (state_reg == ARM) || (state_reg == MEASURE);
  assign afe_reset = (state_reg == DISCHARGE);
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == FINISH);
  assign result    = result_reg;
  assign overflow  = overflow_reg;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Rise takes priority over timeout; abort takes priority over everything.
  always_comb begin
    state_next = state_reg;
    load_last  = 1'b0;
    load_tout  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) state_next = DISCHARGE;
      end
      DISCHARGE: begin
        if (abort)                         state_next = IDLE;
        else if (disch_cnt_reg == DC_LAST) state_next = ARM;
      end
      ARM: begin
        if (abort)                    state_next = IDLE;
        else if (rise)                state_next = MEASURE;
        else if (cnt_reg == CNT_MAX) begin
          state_next = FINISH;
          load_tout  = 1'b1;
        end
      end
      MEASURE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (rise) begin
          if (scnt_reg == SC_LAST) begin
            state_next = FINISH;
            load_last  = 1'b1;
          end
        end else if (cnt_reg == CNT_MAX) begin
          state_next = FINISH;
          load_tout  = 1'b1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Period counter is reloaded with 1 (not 0) so that its value on the next
  // rise equals the distance in cycles between the two rises.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      sync_prev_reg <= 1'b0;
      disch_cnt_reg <= '0;
      cnt_reg       <= '0;
      scnt_reg      <= '0;
      acc_reg       <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      sync1_reg     <= trigger;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;

      disch_cnt_reg <= (state_reg == DISCHARGE) ? disch_cnt_reg + 1'b1 : '0;

      if (state_reg != ARM && state_next == ARM) begin
        cnt_reg <= CNT_W'(1);
      end else if (counting && rise) begin
        cnt_reg <= CNT_W'(1);
      end else if (counting && cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (state_reg == ARM && rise) begin
        acc_reg  <= '0;
        scnt_reg <= '0;
      end else if (state_reg == MEASURE && rise && !abort) begin
        acc_reg  <= acc_sum;
        scnt_reg <= scnt_reg + 1'b1;
      end

      if (load_last) begin
        result_reg   <= acc_sum[ACC_W-1:AVG_LOG2];
        overflow_reg <= 1'b0;
      end else if (load_tout) begin
        result_reg   <= CNT_MAX;
        overflow_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// Directed bench for meas_seq_ctrl: averaging, timeout, abort, reset, start filtering.
module tb_meas_seq_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       trigger = 1'b0;
  logic       afe_reset;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  // monitor state, written only by the monitor process
  int   cyc = 0;
  int   done_total = 0;
  int   afe_total = 0;
  int   done_cyc = 0;
  int   arm_cyc = 0;
  int   trig_cyc = 0;
  logic done_d = 1'b0;
  logic afe_d = 1'b0;
  logic trig_d = 1'b0;
  logic busy_after = 1'b1;

  meas_seq_ctrl #(.CNT_W(8), .AVG_LOG2(2), .RST_CYC(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .abort     (abort),
    .trigger   (trigger),
    .afe_reset (afe_reset),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc    <= cyc + 1;
    done_d <= done;
    afe_d  <= afe_reset;
    trig_d <= trigger;
    if (done) begin
      done_total <= done_total + 1;
      done_cyc   <= cyc;
    end
    if (done_d) busy_after <= busy;
    if (afe_reset) afe_total <= afe_total + 1;
    if (afe_d && !afe_reset) arm_cyc <= cyc;
    if (trigger && !trig_d) trig_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
  endtask

  // Five rising edges spaced by the four given periods; poke raises start at each edge.
  task automatic train(input int p0, input int p1, input int p2, input int p3, input bit poke);
    int per[4];
    per = '{p0, p1, p2, p3};
    for (int i = 0; i < 5; i++) begin
      trigger = 1'b1;
      start   = poke;
      tick(1);
      start   = 1'b0;
      tick(2);
      trigger = 1'b0;
      if (i < 4) tick(per[i] - 3);
    end
  endtask

  task automatic wait_done(input int base);
    for (int i = 0; i < 400 && done_total == base; i++) tick(1);
    tick(2);
  endtask

  int base_done, base_afe;

  initial begin
    tick(2);
    check("reset_outputs", {23'd0, afe_reset, busy, done, overflow, result}, 32'd0);
    n_rst = 1'b1;
    tick(2);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // period 20 square wave
    base_done = done_total; base_afe = afe_total;
    go();
    train(20, 20, 20, 20, 1'b0);
    wait_done(base_done);
    check("p20_done_cnt", done_total - base_done, 1);
    check("p20_afe_cycles", afe_total - base_afe, 4);
    check("p20_result", {24'd0, result}, 20);
    check("p20_overflow", {31'd0, overflow}, 0);
    check("p20_busy_after_done", {31'd0, busy_after}, 0);
    check("p20_done_latency", done_cyc - trig_cyc, 3);
    $display("txn p20: result=%0d overflow=%0b", result, overflow);

    // periods 10..13 -> 46 >> 2 = 11
    base_done = done_total;
    go();
    train(10, 11, 12, 13, 1'b0);
    wait_done(base_done);
    check("avg_done_cnt", done_total - base_done, 1);
    check("avg_result", {24'd0, result}, 11);
    check("avg_overflow", {31'd0, overflow}, 0);
    $display("txn avg: result=%0d overflow=%0b", result, overflow);

    // trigger held low -> timeout
    base_done = done_total;
    go();
    wait_done(base_done);
    check("tout_done_cnt", done_total - base_done, 1);
    check("tout_result", {24'd0, result}, 255);
    check("tout_overflow", {31'd0, overflow}, 1);
    check("tout_cycles", done_cyc - arm_cyc, 255);
    $display("txn timeout: result=%0d overflow=%0b", result, overflow);

    // abort during second sample
    base_done = done_total;
    go();
    trigger = 1'b1; tick(3); trigger = 1'b0; tick(17);
    trigger = 1'b1; tick(3); trigger = 1'b0; tick(7);
    check("abort_busy_before", {31'd0, busy}, 1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("abort_busy_next", {31'd0, busy}, 0);
    check("abort_afe", {31'd0, afe_reset}, 0);
    tick(40);
    check("abort_no_done", done_total - base_done, 0);
    check("abort_result_kept", {24'd0, result}, 255);
    check("abort_overflow_kept", {31'd0, overflow}, 1);
    $display("txn abort: result=%0d overflow=%0b", result, overflow);

    // reset mid-measurement
    go();
    trigger = 1'b1; tick(3); trigger = 1'b0; tick(17);
    trigger = 1'b1; tick(3); trigger = 1'b0; tick(5);
    n_rst = 1'b0;
    #1;
    check("rst_mid_outputs", {23'd0, afe_reset, busy, done, overflow, result}, 32'd0);
    tick(2);
    n_rst = 1'b1;
    tick(10);
    check("rst_release_idle", {31'd0, busy}, 0);
    base_done = done_total;
    go();
    train(20, 20, 20, 20, 1'b0);
    wait_done(base_done);
    check("rst_rerun_done_cnt", done_total - base_done, 1);
    check("rst_rerun_result", {24'd0, result}, 20);
    check("rst_rerun_overflow", {31'd0, overflow}, 0);
    $display("txn reset_rerun: result=%0d overflow=%0b", result, overflow);

    // start+abort in IDLE, then start pulses while busy
    base_done = done_total;
    start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(1);
    check("start_abort_idle", {31'd0, busy}, 0);
    start = 1'b1; tick(1); start = 1'b0;
    tick(2);
    start = 1'b1; tick(1); start = 1'b0;
    tick(3);
    train(12, 12, 12, 12, 1'b1);
    wait_done(base_done);
    tick(40);
    check("ign_done_cnt", done_total - base_done, 1);
    check("ign_result", {24'd0, result}, 12);
    check("ign_busy_end", {31'd0, busy}, 0);
    $display("txn start_filter: result=%0d overflow=%0b", result, overflow);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
